// File: rtl/ones_pkg.sv
// Shared state encoding for the ones-pattern generator and any block that
// decodes its st output.
package ones_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam int ST_W = 2;

endpackage

// File: rtl/ones_cnt_down.sv
// Loadable down-counter: load wins over dec, dec stops at zero.
module ones_cnt_down #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic         zero
);

  logic [W-1:0] q;

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= d;
    else if (dec && (q != '0))
      q <= q - 1'b1;
  end

  // Zero flag steers the FSM out of the shift phase
  always_comb begin
    zero = (q == '0);
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// Generates a word of min(count,N) right-justified ones by shifting a 1 in
// per cycle, then holds it in S_DONE until s drops.
module ones_pattern_gen
  import ones_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic [CW-1:0] count,
  output logic [N-1:0]  Result,
  output logic          done,
  output logic [1:0]    st
);

  state_t        state, next_state;
  logic [CW-1:0] sat_count;
  logic          load, dec, zero;

  // Counts above N would shift ones out the top; clamp to N
  always_comb begin
    sat_count = (count > CW'(N)) ? CW'(N) : count;
  end

  // Counter controls: reload continuously while idle, so count is only
  // captured on the edge that leaves S_IDLE
  always_comb begin
    load = (state == S_IDLE);
    dec  = (state == S_SHIFT) && s && !zero;
  end

  ones_cnt_down #(.W(CW)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .dec  (dec),
    .d    (sat_count),
    .zero (zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; the unused encoding recovers to S_IDLE
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = s ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        if (!s)
          next_state = S_IDLE;
        else if (zero)
          next_state = S_DONE;
        else
          next_state = S_SHIFT;
      end
      S_DONE:  next_state = s ? S_DONE : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    done = (state == S_DONE);
    st   = state;
  end

  // Result shift register: cleared while idle, shifts a 1 in per decrement,
  // holds on abort so the partial word is visible for one cycle
  always_ff @(posedge clk) begin
    if (!rst_n)
      Result <= '0;
    else if (state == S_IDLE)
      Result <= '0;
    else if (dec)
      Result <= {Result[N-2:0], 1'b1};
  end

endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 SHALL have parameter N, default 8, the output word width; legal range 2..32.
REQ-002 SHALL have derived localparam CW = $clog2(N+1), the width of the count input.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port s, input, 1, start/hold level: 0 = load/idle, 1 = run.
REQ-006 SHALL have port count, input, CW, the number of ones to generate.
REQ-007 SHALL have port Result, output, N, the generated word, registered.
REQ-008 SHALL have port done, output, 1, high while the FSM is in S_DONE (Moore).
REQ-009 SHALL have port st, output, 2, the current FSM state encoding.

Function
REQ-010 SHALL implement states S_IDLE=2'b00, S_SHIFT=2'b01 and S_DONE=2'b10; 2'b11 is illegal and SHALL go to S_IDLE on the next edge.
REQ-011 In S_IDLE on every edge, SHALL set Result<=0 and cnt<=min(count,N), where count>N saturates to N.
REQ-012 S_IDLE with s=1 SHALL go to S_SHIFT on the same edge that loads cnt; S_IDLE with s=0 SHALL stay in S_IDLE.
REQ-013 S_SHIFT with s=1 and cnt!=0 SHALL set Result<={Result[N-2:0],1'b1} and cnt<=cnt-1, staying in S_SHIFT.
REQ-014 S_SHIFT with s=1 and cnt==0 SHALL go to S_DONE with Result unchanged.
REQ-015 S_SHIFT with s=0 (abort) SHALL go to S_IDLE with Result unchanged on that edge; S_IDLE then clears it on the following edge.
REQ-016 S_DONE SHALL hold Result while s=1 and SHALL go to S_IDLE when s=0.
REQ-017 Final Result SHALL equal (1<<c)-1, where c = min(count,N) sampled on the edge leaving S_IDLE; changes to count after that edge are ignored.
REQ-018 Latency: done SHALL rise c+1 edges after the edge leaving S_IDLE; for c=0, one edge after, with Result=0.
REQ-019 For c=N, Result SHALL equal all ones; no bit SHALL shift out or wrap.
REQ-020 done SHALL be high exactly when st==S_DONE.

Reset
REQ-021 With rst_n=0 at a rising edge, SHALL set st=S_IDLE, Result=0, cnt=0 and done=0, overriding s and count.
REQ-022 Reset mid-S_SHIFT or mid-S_DONE SHALL abort the run without completing it.
REQ-023 Reset SHALL take priority over all transitions.
REQ-024 After release, the FSM SHALL resume S_IDLE behaviour on the first edge.

Structure
REQ-025 Shared package ones_pkg SHALL hold the typedef enum logic [1:0] state_t and the S_IDLE, S_SHIFT and S_DONE encodings.
REQ-026 The consuming bit-counter block SHALL import ones_pkg for identical st decoding.
REQ-027 SHALL contain one sub-module, ones_cnt_down: a CW-bit loadable down-counter with load, dec and zero flag.
REQ-028 Control FSM and Result shift register SHALL reside in ones_pattern_gen.

Verification
REQ-029 Normal run: N=8, count=5, s=1 held -> st 00->01 (x6)->10; Result=8'b0001_1111; done high 6 edges after leaving S_IDLE.
REQ-030 Zero count: count=0, s=1 -> S_DONE one edge after leaving S_IDLE, with Result=8'h00 and done=1.
REQ-031 Saturation: count=4'd13, N=8 -> Result=8'hFF and done after 9 edges; count=8 gives the identical result.
REQ-032 Abort: count=6, s dropped after 3 shifts -> st=S_IDLE next edge with Result=8'h07, then 8'h00 one edge later; done never asserted.
REQ-033 Reset: rst_n=0 for one edge during S_SHIFT (Result=8'h03) -> st=00, Result=00, done=0; a later s=1 run with count=2 yields 8'h03.
REQ-034 Round-trip: feed Result to the bit-counter block for count=0..8 -> its Result equals the original count each time.
